// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: register bus, control-unit handshakes and dispatch outputs of the interrupt controller.
// Signals:
//   i_Enable                 clock enable
//   i_Request[4:0]           peripheral request pulses (VBlank, STAT, Timer, Serial, Joypad)
//   i_Sel_IF / i_Sel_IE      register selects for 0xFF0F / 0xFFFF
//   i_Write, i_Data          register write strobe and data
//   o_Data                   register read data
//   i_EI / i_DI / i_RETI     control-unit pulses
//   i_Instr_Boundary         opcode fetch pulse
//   i_Ack / i_Dispatch_Done  dispatch start / end
//   o_Interrupts, o_IRQ, o_Wake, o_Vector, o_IME  controller status
interface interrupt_controller_if;
    logic       i_Enable;
    logic [4:0] i_Request;
    logic       i_Sel_IF;
    logic       i_Sel_IE;
    logic       i_Write;
    logic [7:0] i_Data;
    logic [7:0] o_Data;
    logic       i_EI;
    logic       i_DI;
    logic       i_RETI;
    logic       i_Instr_Boundary;
    logic       i_Ack;
    logic       i_Dispatch_Done;
    logic [4:0] o_Interrupts;
    logic       o_IRQ;
    logic       o_Wake;
    logic [7:0] o_Vector;
    logic       o_IME;
    modport master (
        output i_Enable, i_Request, i_Sel_IF, i_Sel_IE, i_Write, i_Data,
               i_EI, i_DI, i_RETI, i_Instr_Boundary, i_Ack, i_Dispatch_Done,
        input  o_Data, o_Interrupts, o_IRQ, o_Wake, o_Vector, o_IME
    );
    modport slave (
        input  i_Enable, i_Request, i_Sel_IF, i_Sel_IE, i_Write, i_Data,
               i_EI, i_DI, i_RETI, i_Instr_Boundary, i_Ack, i_Dispatch_Done,
        output o_Data, o_Interrupts, o_IRQ, o_Wake, o_Vector, o_IME
    );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: IF/IE registers, fixed-priority dispatch FSM and IME FSM.
// Ports: i_Clk (clock), i_Reset (sync active-high reset), bus (interrupt_controller_if.slave).
// Macro INTC_EI_DELAY_EN: when defined EI arms IME and it turns on at the next instruction
// boundary; when undefined EI turns IME on at the next edge.
module interrupt_controller (
    input logic                   i_Clk,
    input logic                   i_Reset,
    interrupt_controller_if.slave bus
);
    typedef enum logic {IDLE, DISPATCH} disp_t;
    typedef enum logic [1:0] {OFF, ARMED, ON} ime_t;
    disp_t      disp, disp_next;
    ime_t       ime, ime_next;
    logic [4:0] flags, flags_next, pend, clr;
    logic [7:0] ie, ie_next, vec, vec_next;
    logic       take;
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            disp  <= IDLE;
            ime   <= OFF;
            flags <= 5'd0;
            ie    <= 8'd0;
            vec   <= 8'd0;
        end else if (bus.i_Enable) begin
            disp  <= disp_next;
            ime   <= ime_next;
            flags <= flags_next;
            ie    <= ie_next;
            vec   <= vec_next;
        end
    end
    assign pend             = ie[4:0] & flags;
    assign bus.o_Interrupts = pend;
    assign bus.o_Wake       = |pend;
    assign bus.o_IME        = ime == ON;
    assign bus.o_IRQ        = ime == ON && |pend && disp == IDLE;
    assign bus.o_Vector     = vec;
    assign bus.o_Data       = bus.i_Sel_IF ? {3'b111, flags} : bus.i_Sel_IE ? ie : 8'h00;
    always_comb begin
        take     = disp == IDLE && bus.i_Ack;
        clr      = 5'd0;
        vec_next = take ? 8'h00 : vec;
        // scan downward so the lowest pending bit (highest priority) is the last one written
        for (int n = 4; n >= 0; n--) begin
            if (take && pend[n]) begin
                clr      = 5'(1 << n);
                vec_next = 8'(8'h40 + n * 8);
            end
        end
        // a request in the same cycle as its clear wins, so OR it in last
        flags_next = ((bus.i_Write && bus.i_Sel_IF) ? bus.i_Data[4:0] : flags) & ~clr | bus.i_Request;
        ie_next    = (bus.i_Write && bus.i_Sel_IE) ? bus.i_Data : ie;
        disp_next  = take ? DISPATCH : (disp == DISPATCH && bus.i_Dispatch_Done) ? IDLE : disp;
        ime_next   = ime;
        if (bus.i_DI || take)
            ime_next = OFF;
        else if (bus.i_RETI)
            ime_next = ON;
        else if (bus.i_EI && ime == OFF)
`ifdef INTC_EI_DELAY_EN
            ime_next = ARMED;
        else if (ime == ARMED && bus.i_Instr_Boundary)
            ime_next = ON;
`else
            ime_next = ON;
`endif
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed and randomized checks of interrupt_controller against a behavioural model.
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    interrupt_controller_if bus();
    interrupt_controller dut (.i_Clk(clk), .i_Reset(rst), .bus(bus));
    // model state: interrupt flags, enables, master enable (0 off, 1 armed, 2 on), dispatching, vector
    logic [4:0] m_if;
    logic [7:0] m_ie;
    int         m_ime;
    bit         m_disp;
    logic [7:0] m_vec;
    function automatic logic [4:0] m_pend();
        return m_ie[4:0] & m_if;
    endfunction
    function automatic logic m_irq();
        return m_ime == 2 && m_pend() != 0 && !m_disp;
    endfunction
    function automatic logic [7:0] m_data();
        if (bus.i_Sel_IF) return {3'b111, m_if};
        if (bus.i_Sel_IE) return m_ie;
        return 8'h00;
    endfunction
    task automatic model_step();
        logic [4:0] p, clr, base;
        bit         taken;
        if (rst) begin
            m_if = 0; m_ie = 0; m_ime = 0; m_disp = 0; m_vec = 0;
            return;
        end
        if (!bus.i_Enable) return;
        p = m_pend();
        clr = 0;
        taken = !m_disp && bus.i_Ack;
        if (taken) begin
            m_vec = 8'h00;
            for (int n = 0; n < 5; n++)
                if (p[n]) begin
                    m_vec = 8'(64 + 8 * n);
                    clr[n] = 1'b1;
                    break;
                end
        end
        base = (bus.i_Write && bus.i_Sel_IF) ? bus.i_Data[4:0] : m_if;
        m_if = (base & ~clr) | bus.i_Request;
        if (bus.i_Write && bus.i_Sel_IE) m_ie = bus.i_Data;
        if (bus.i_DI || taken) m_ime = 0;
        else if (bus.i_RETI) m_ime = 2;
`ifdef INTC_EI_DELAY_EN
        else if (bus.i_EI && m_ime == 0) m_ime = 1;
        else if (m_ime == 1 && bus.i_Instr_Boundary) m_ime = 2;
`else
        else if (bus.i_EI && m_ime == 0) m_ime = 2;
`endif
        if (taken) m_disp = 1;
        else if (m_disp && bus.i_Dispatch_Done) m_disp = 0;
    endtask
    task automatic clear_pulses();
        rst = 0;
        bus.i_Request = 0; bus.i_Write = 0; bus.i_Data = 0;
        bus.i_EI = 0; bus.i_DI = 0; bus.i_RETI = 0;
        bus.i_Instr_Boundary = 0; bus.i_Ack = 0; bus.i_Dispatch_Done = 0;
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        clear_pulses();
    endtask
    task automatic do_reset();
        rst = 1;
        tick();
    endtask
    task automatic write_reg(input bit to_ie, input logic [7:0] d);
        bus.i_Sel_IF = !to_ie; bus.i_Sel_IE = to_ie;
        bus.i_Write = 1; bus.i_Data = d;
        tick();
        bus.i_Sel_IF = 0; bus.i_Sel_IE = 0;
    endtask
    task automatic test_reset();
        bus.i_Enable = 1; bus.i_Sel_IF = 0; bus.i_Sel_IE = 0;
        clear_pulses();
        do_reset();
        bus.i_Sel_IF = 1; #1;
        n_cmp++; if (bus.o_Data !== 8'hE0) begin n_err++; $display("FAIL reset_if got %h want e0", bus.o_Data); end
        bus.i_Sel_IF = 0; bus.i_Sel_IE = 1; #1;
        n_cmp++; if (bus.o_Data !== 8'h00) begin n_err++; $display("FAIL reset_ie got %h want 00", bus.o_Data); end
        bus.i_Sel_IE = 0; #1;
        n_cmp++; if ({bus.o_IRQ, bus.o_Wake, bus.o_IME, bus.o_Interrupts, bus.o_Vector} !== 16'h0)
            begin n_err++; $display("FAIL reset_outs got %b%b%b %h %h want all zero", bus.o_IRQ, bus.o_Wake, bus.o_IME, bus.o_Interrupts, bus.o_Vector); end
    endtask
    task automatic test_dispatch();
        do_reset();
        write_reg(1, 8'h1F);
        bus.i_RETI = 1; tick();
        bus.i_Request = 5'b10100; tick();
        n_cmp++; if (bus.o_IRQ !== 1'b1) begin n_err++; $display("FAIL disp_irq got %b want 1", bus.o_IRQ); end
        bus.i_Ack = 1; tick();
        bus.i_Sel_IF = 1; #1;
        n_cmp++; if (bus.o_Vector !== 8'h50) begin n_err++; $display("FAIL disp_vec got %h want 50", bus.o_Vector); end
        n_cmp++; if (bus.o_Data !== 8'hF0) begin n_err++; $display("FAIL disp_if got %h want f0", bus.o_Data); end
        n_cmp++; if (bus.o_IME !== 1'b0 || bus.o_IRQ !== 1'b0) begin n_err++; $display("FAIL disp_ime got ime=%b irq=%b want 0 0", bus.o_IME, bus.o_IRQ); end
        bus.i_Sel_IF = 0;
        bus.i_Ack = 1; bus.i_RETI = 1; bus.i_Dispatch_Done = 1; tick();
        n_cmp++; if (bus.o_IRQ !== 1'b1 || bus.o_Vector !== 8'h50) begin n_err++; $display("FAIL disp_ignored_ack got irq=%b vec=%h want 1 50", bus.o_IRQ, bus.o_Vector); end
        bus.i_DI = 1; tick();
        n_cmp++; if (bus.o_IRQ !== 1'b0 || bus.o_Wake !== 1'b1) begin n_err++; $display("FAIL disp_done got irq=%b wake=%b want 0 1", bus.o_IRQ, bus.o_Wake); end
    endtask
    task automatic test_wake();
        do_reset();
        write_reg(1, 8'h04);
        bus.i_Request = 5'b00100; tick();
        n_cmp++; if (bus.o_Wake !== 1'b1 || bus.o_IRQ !== 1'b0 || bus.o_Interrupts !== 5'b00100)
            begin n_err++; $display("FAIL wake got wake=%b irq=%b ints=%b want 1 0 00100", bus.o_Wake, bus.o_IRQ, bus.o_Interrupts); end
    endtask
    task automatic test_same_cycle_request();
        do_reset();
        write_reg(1, 8'h01);
        bus.i_RETI = 1; tick();
        bus.i_Request = 5'b00001; tick();
        bus.i_Ack = 1; bus.i_Request = 5'b00001; tick();
        bus.i_Sel_IF = 1; #1;
        n_cmp++; if (bus.o_Data !== 8'hE1 || bus.o_Vector !== 8'h40) begin n_err++; $display("FAIL sameclr got if=%h vec=%h want e1 40", bus.o_Data, bus.o_Vector); end
        bus.i_Sel_IF = 0;
    endtask
    task automatic test_ei();
        do_reset();
`ifdef INTC_EI_DELAY_EN
        bus.i_EI = 1; bus.i_Instr_Boundary = 1; tick();
        n_cmp++; if (bus.o_IME !== 1'b0) begin n_err++; $display("FAIL ei_armed got %b want 0", bus.o_IME); end
        tick();
        n_cmp++; if (bus.o_IME !== 1'b0) begin n_err++; $display("FAIL ei_wait got %b want 0", bus.o_IME); end
        bus.i_Instr_Boundary = 1; tick();
        n_cmp++; if (bus.o_IME !== 1'b1) begin n_err++; $display("FAIL ei_on got %b want 1", bus.o_IME); end
        bus.i_DI = 1; tick();
        bus.i_EI = 1; tick();
        bus.i_DI = 1; tick();
        bus.i_Instr_Boundary = 1; tick();
        n_cmp++; if (bus.o_IME !== 1'b0) begin n_err++; $display("FAIL ei_di got %b want 0", bus.o_IME); end
`else
        bus.i_EI = 1; tick();
        n_cmp++; if (bus.o_IME !== 1'b1) begin n_err++; $display("FAIL ei_on got %b want 1", bus.o_IME); end
        bus.i_EI = 1; bus.i_DI = 1; tick();
        n_cmp++; if (bus.o_IME !== 1'b0) begin n_err++; $display("FAIL ei_di got %b want 0", bus.o_IME); end
`endif
        bus.i_RETI = 1; bus.i_DI = 1; tick();
        n_cmp++; if (bus.o_IME !== 1'b0) begin n_err++; $display("FAIL reti_di got %b want 0", bus.o_IME); end
    endtask
    task automatic test_ack_empty();
        do_reset();
        write_reg(1, 8'h1F);
        bus.i_RETI = 1; bus.i_Request = 5'h1F; tick();
        bus.i_Ack = 1; tick();
        bus.i_Dispatch_Done = 1; bus.i_RETI = 1; tick();
        n_cmp++; if (bus.o_Vector !== 8'h40) begin n_err++; $display("FAIL empty_pre got %h want 40", bus.o_Vector); end
        write_reg(0, 8'h00);
        bus.i_Ack = 1; tick();
        n_cmp++; if (bus.o_Vector !== 8'h00 || bus.o_IME !== 1'b0) begin n_err++; $display("FAIL empty_ack got vec=%h ime=%b want 00 0", bus.o_Vector, bus.o_IME); end
    endtask
    task automatic test_enable();
        do_reset();
        bus.i_Enable = 0;
        bus.i_Request = 5'h1F; bus.i_RETI = 1; bus.i_Sel_IE = 1; bus.i_Write = 1; bus.i_Data = 8'hFF; tick();
        bus.i_Sel_IE = 0; bus.i_Sel_IF = 1; #1;
        n_cmp++; if (bus.o_Data !== 8'hE0 || bus.o_IME !== 1'b0) begin n_err++; $display("FAIL enable_hold got if=%h ime=%b want e0 0", bus.o_Data, bus.o_IME); end
        bus.i_Enable = 1; bus.i_Request = 5'h03; tick();
        bus.i_Enable = 0; rst = 1; tick();
        n_cmp++; if (bus.o_Data !== 8'hE0) begin n_err++; $display("FAIL enable_reset got %h want e0", bus.o_Data); end
        bus.i_Enable = 1; bus.i_Sel_IF = 0;
    endtask
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 99) == 0;
            bus.i_Enable = $urandom_range(0, 9) != 0;
            bus.i_Request = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            bus.i_Sel_IF = $urandom_range(0, 2) == 0;
            bus.i_Sel_IE = $urandom_range(0, 2) == 0;
            bus.i_Write = $urandom_range(0, 5) == 0;
            bus.i_Data = 8'($urandom);
            bus.i_EI = $urandom_range(0, 7) == 0;
            bus.i_DI = $urandom_range(0, 11) == 0;
            bus.i_RETI = $urandom_range(0, 11) == 0;
            bus.i_Instr_Boundary = $urandom_range(0, 2) == 0;
            bus.i_Ack = bus.o_IRQ ? $urandom_range(0, 1) == 1 : $urandom_range(0, 15) == 0;
            bus.i_Dispatch_Done = $urandom_range(0, 3) == 0;
            tick();
            n_cmp++;
            if (bus.o_Interrupts !== m_pend() || bus.o_IRQ !== m_irq() || bus.o_Wake !== (m_pend() != 0) ||
                bus.o_Vector !== m_vec || bus.o_IME !== (m_ime == 2) || bus.o_Data !== m_data()) begin
                n_err++;
                $display("FAIL rand[%0d] got ints=%b irq=%b wake=%b vec=%h ime=%b data=%h want ints=%b irq=%b wake=%b vec=%h ime=%b data=%h",
                         i, bus.o_Interrupts, bus.o_IRQ, bus.o_Wake, bus.o_Vector, bus.o_IME, bus.o_Data,
                         m_pend(), m_irq(), m_pend() != 0, m_vec, m_ime == 2, m_data());
            end
        end
    endtask
    initial begin
        test_reset();
        test_dispatch();
        test_wake();
        test_same_cycle_request();
        test_ei();
        test_ack_empty();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
